// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
//
// Contents:
//   SEG_HEX[0:15]  segment patterns {dp,g..a} for hex digits 0..F (active-high)
//   SEG_OFF        all segments off
//   SEG_DASH       centre bar only
//   seg_decode()   nibble -> segment pattern
//   value_width()  bits needed to hold 0..n-1 (never less than 1)
package seg_scan_pkg;

    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
        8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71
    };

    localparam logic [7:0] SEG_OFF  = 8'h00;
    localparam logic [7:0] SEG_DASH = 8'h40;

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

    function automatic int value_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timing for seg_scan_driver: slot prescaler, digit index, frame wrap,
// and the blink phase derived from a count of completed frames.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick         last cycle of the current digit slot
//   idx          digit currently being scanned (0 = rightmost)
//   wrap         last cycle of the last slot of a frame
//   blink_phase  0 = blinking digits lit, 1 = blinking digits dark
//   in_blank     current cycle lies in the anti-ghosting window of the slot
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV_PERIOD = 125000,
    parameter int BLANK_CYCLES   = 64,
    parameter int BLINK_FRAMES   = 50,
    parameter int IDX_W          = value_width(DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             blink_phase,
    output logic             in_blank
);

    localparam int CNT_W = value_width(CLK_DIV_PERIOD);
    localparam int FRM_W = value_width(BLINK_FRAMES);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV_PERIOD - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    assign tick        = (cnt_q == CNT_LAST);
    assign wrap        = tick && (idx_q == IDX_LAST);
    assign idx         = idx_q;
    assign blink_phase = blink_phase_q;
    assign in_blank    = (cnt_q < BLANK_END);

    always_comb begin
        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        idx_d         = idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Blink half-period is measured in whole frames so a digit never
        // changes blink state part-way through a scan.
        if (wrap) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scanner for DIGITS hex digits on a common-cathode
// display. Values are loaded into a shadow copy at any time and committed to
// the displayed (active) copy only at frame wrap, so a frame never tears.
//
// Optional build macro: DECIMAL_POINT_EN adds dp_in; the per-digit decimal
// point then drives digital_leds[7] whenever that digit is lit.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   digits_in     nibble i at [4i+3:4i], digit 0 rightmost
//   show          1 = hex values, 0 = MASK_PATTERN on every digit
//   blink_mask    bit i blinks digit i
//   dp_in         (DECIMAL_POINT_EN only) per-digit decimal point
//   load          one-cycle strobe capturing the inputs above
//   disps         active-low digit enables (registered)
//   digital_leds  segments {dp,g..a}, active-high (registered)
//   frame_done    one-cycle pulse after the scan wraps to digit 0
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int         DIGITS         = 4,
    parameter int         CLK_DIV_PERIOD = 125000,
    parameter int         BLANK_CYCLES   = 64,
    parameter int         BLINK_FRAMES   = 50,
    parameter logic [7:0] MASK_PATTERN   = 8'h02
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic                  show,
    input  logic [DIGITS-1:0]     blink_mask,
`ifdef DECIMAL_POINT_EN
    input  logic [DIGITS-1:0]     dp_in,
`endif
    input  logic                  load,
    output logic [DIGITS-1:0]     disps,
    output logic [7:0]            digital_leds,
    output logic                  frame_done
);

    localparam int IDX_W = value_width(DIGITS);

    logic             tick;
    logic [IDX_W-1:0] idx;
    logic             wrap;
    logic             blink_phase;
    logic             in_blank;
    logic             commit;

    seg_scan_timer #(
        .DIGITS         (DIGITS),
        .CLK_DIV_PERIOD (CLK_DIV_PERIOD),
        .BLANK_CYCLES   (BLANK_CYCLES),
        .BLINK_FRAMES   (BLINK_FRAMES),
        .IDX_W          (IDX_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .idx         (idx),
        .wrap        (wrap),
        .blink_phase (blink_phase),
        .in_blank    (in_blank)
    );

    // wrap only ever occurs on a tick; qualifying with tick keeps the commit
    // pinned to a slot boundary.
    assign commit = tick && wrap;

    logic [4*DIGITS-1:0] shadow_digits_q, shadow_digits_d;
    logic                shadow_show_q,   shadow_show_d;
    logic [DIGITS-1:0]   shadow_blink_q,  shadow_blink_d;
    logic [4*DIGITS-1:0] act_digits_q,    act_digits_d;
    logic                act_show_q,      act_show_d;
    logic [DIGITS-1:0]   act_blink_q,     act_blink_d;
`ifdef DECIMAL_POINT_EN
    logic [DIGITS-1:0]   shadow_dp_q,     shadow_dp_d;
    logic [DIGITS-1:0]   act_dp_q,        act_dp_d;
`endif

    logic [DIGITS-1:0]   disps_q,      disps_d;
    logic [7:0]          leds_q,       leds_d;
    logic                frame_done_q, frame_done_d;

    // Load path: shadow_*_d already reflects a load in this cycle, so
    // committing it at wrap gives a coincident load immediate effect.
    always_comb begin
        shadow_digits_d = load ? digits_in  : shadow_digits_q;
        shadow_show_d   = load ? show       : shadow_show_q;
        shadow_blink_d  = load ? blink_mask : shadow_blink_q;
        act_digits_d    = commit ? shadow_digits_d : act_digits_q;
        act_show_d      = commit ? shadow_show_d   : act_show_q;
        act_blink_d     = commit ? shadow_blink_d  : act_blink_q;
`ifdef DECIMAL_POINT_EN
        shadow_dp_d     = load ? dp_in : shadow_dp_q;
        act_dp_d        = commit ? shadow_dp_d : act_dp_q;
`endif
    end

    // Output path: registered view of the digit selected by idx.
    always_comb begin
        logic [3:0] nibble;
        logic       dark;

        nibble       = act_digits_q[{idx, 2'b00} +: 4];
        dark         = blink_phase && act_blink_q[idx];
        disps_d      = '1;
        leds_d       = SEG_OFF;
        frame_done_d = wrap;

        if (!in_blank && !dark) begin
            disps_d[idx] = 1'b0;
            leds_d       = act_show_q ? seg_decode(nibble) : MASK_PATTERN;
`ifdef DECIMAL_POINT_EN
            leds_d[7]    = act_dp_q[idx];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_digits_q <= '0;
            shadow_show_q   <= 1'b0;
            shadow_blink_q  <= '0;
            act_digits_q    <= '0;
            act_show_q      <= 1'b0;
            act_blink_q     <= '0;
`ifdef DECIMAL_POINT_EN
            shadow_dp_q     <= '0;
            act_dp_q        <= '0;
`endif
            disps_q         <= '1;
            leds_q          <= SEG_OFF;
            frame_done_q    <= 1'b0;
        end else begin
            shadow_digits_q <= shadow_digits_d;
            shadow_show_q   <= shadow_show_d;
            shadow_blink_q  <= shadow_blink_d;
            act_digits_q    <= act_digits_d;
            act_show_q      <= act_show_d;
            act_blink_q     <= act_blink_d;
`ifdef DECIMAL_POINT_EN
            shadow_dp_q     <= shadow_dp_d;
            act_dp_q        <= act_dp_d;
`endif
            disps_q         <= disps_d;
            leds_q          <= leds_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign disps        = disps_q;
    assign digital_leds = leds_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=4, CLK_DIV_PERIOD=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2). The reference model tracks only the number of clocks
// since reset plus the shadow/active value sets; slot, digit, frame and blink
// phase are derived from that count arithmetically.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int PER    = 8;
    localparam int BLANK  = 2;
    localparam int BF     = 2;
    localparam int FRAME  = PER * DIGITS;

    localparam logic [7:0] HEX [16] = '{
        8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07,
        8'h7f, 8'h6f, 8'h77, 8'h7c, 8'h39, 8'h5e, 8'h79, 8'h71
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic        show = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  disps;
    logic [7:0]  digital_leds;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS         (DIGITS),
        .CLK_DIV_PERIOD (PER),
        .BLANK_CYCLES   (BLANK),
        .BLINK_FRAMES   (BF),
        .MASK_PATTERN   (8'h02)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digits_in    (digits_in),
        .show         (show),
        .blink_mask   (blink_mask),
`ifdef DECIMAL_POINT_EN
        .dp_in        (dp_in),
`endif
        .load         (load),
        .disps        (disps),
        .digital_leds (digital_leds),
        .frame_done   (frame_done)
    );

    int tests = 0;
    int fails = 0;
    int n = 0;

    logic [15:0] sh_dig = '0, ac_dig = '0;
    logic        sh_show = 1'b0, ac_show = 1'b0;
    logic [3:0]  sh_blink = '0, ac_blink = '0;
    logic [3:0]  sh_dp = '0, ac_dp = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, want, n);
        end
    endtask

    // One clock: predict registered outputs from pre-edge model state,
    // advance the model with this cycle's inputs, then compare.
    task automatic step();
        logic [3:0] exp_d;
        logic [7:0] exp_l;
        logic       exp_f;
        logic [3:0] sel;
        int         slot, pos, phase;

        exp_d = 4'hF;
        exp_l = 8'h00;
        exp_f = 1'b0;
        if (!rst) begin
            pos   = n % PER;
            slot  = (n / PER) % DIGITS;
            phase = (n / (FRAME * BF)) % 2;
            exp_f = ((n % FRAME) == FRAME - 1);
            if (pos >= BLANK && !(phase == 1 && ac_blink[slot])) begin
                sel   = 4'b0001 << slot;
                exp_d = ~sel;
                exp_l = ac_show ? HEX[ac_dig[slot*4 +: 4]] : 8'h02;
`ifdef DECIMAL_POINT_EN
                exp_l[7] = ac_dp[slot];
`endif
            end
        end

        @(posedge clk);
        if (rst) begin
            n = 0;
            sh_dig = '0; sh_show = 1'b0; sh_blink = '0; sh_dp = '0;
            ac_dig = '0; ac_show = 1'b0; ac_blink = '0; ac_dp = '0;
        end else begin
            if ((n % FRAME) == FRAME - 1) begin
                ac_dig   = load ? digits_in  : sh_dig;
                ac_show  = load ? show       : sh_show;
                ac_blink = load ? blink_mask : sh_blink;
                ac_dp    = load ? dp_in      : sh_dp;
            end
            if (load) begin
                sh_dig = digits_in; sh_show = show; sh_blink = blink_mask; sh_dp = dp_in;
            end
            n++;
        end
        #1;
        check("disps", 32'(disps), 32'(exp_d));
        check("leds", 32'(digital_leds), 32'(exp_l));
        check("frame_done", 32'(frame_done), 32'(exp_f));
        check("onehot", 32'($countones(~disps) <= 1), 32'd1);
    endtask

    task automatic advance_to(input int frame_pos);
        for (int i = 0; i < FRAME && (n % FRAME) != frame_pos; i++) step();
    endtask

    initial begin
        // Reset, then idle: mask pattern walks across the digits.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (70) step();

        // Mid-frame load: old content until next wrap.
        advance_to(13);
        digits_in = 16'h4321; show = 1'b1; load = 1'b1;
        step();
        load = 1'b0; digits_in = 16'($urandom); show = 1'b0;
        repeat (70) step();

        // Load coincident with wrap takes effect for the frame starting there.
        advance_to(FRAME - 1);
        digits_in = 16'hFEDC; show = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        repeat (40) step();

        // Blink digit 1 across several half-periods.
        digits_in = 16'h4321; show = 1'b1; blink_mask = 4'b0010; load = 1'b1;
        step();
        load = 1'b0; blink_mask = 4'b0000;
        repeat (FRAME * 5) step();

`ifdef DECIMAL_POINT_EN
        digits_in = 16'h0000; show = 1'b1; blink_mask = 4'b0000; dp_in = 4'b0100; load = 1'b1;
        step();
        load = 1'b0;
        repeat (70) step();
`endif

        // Randomised traffic; unloaded input changes must be ignored.
        repeat (800) begin
            digits_in  = 16'($urandom);
            show       = 1'($urandom);
            blink_mask = 4'($urandom);
            dp_in      = 4'($urandom);
            load       = ($urandom_range(0, 15) == 0);
            step();
        end
        load = 1'b0;

        // Reset during slot 2.
        advance_to(2 * PER + 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
